// File: rtl/tile_spawner.sv
// tile_spawner: places a new 2/4 tile into a pseudo-random empty cell of the 4x4
// board through its preset port, then confirms the write on the live board state.
module tile_spawner #(
   parameter logic [15:0] LFSR_SEED       = 16'hACE1,
   parameter int          FOUR_THRESH     = 2,
   parameter int          CONFIRM_TIMEOUT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        spawn_req,
   input  logic        spawn_two,
   input  logic [63:0] total_current_state,
   output logic        preset_ext,
   output logic [3:0]  preset_location,
   output logic [3:0]  value_from_preset,
   output logic        busy,
   output logic        spawn_done,
   output logic        board_full,
   output logic        spawn_error
);

   localparam logic [15:0] SEED     = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
   localparam logic [15:0] TAPS     = 16'hB400;
   localparam int          THRESH_C = (FOUR_THRESH < 0) ? 0 :
                                      ((FOUR_THRESH > 16) ? 16 : FOUR_THRESH);
   localparam logic [4:0]  THRESH   = THRESH_C[4:0];
   // The confirm window is counted from the write strobe, so the error pulse lands
   // CONFIRM_TIMEOUT cycles after the PRESET cycle.
   localparam int          TMO_C    = (CONFIRM_TIMEOUT < 2) ? 0 :
                                      ((CONFIRM_TIMEOUT > 257) ? 255 : CONFIRM_TIMEOUT - 2);
   localparam logic [7:0]  TMO_LAST = TMO_C[7:0];

   typedef enum logic [1:0] {
      S_IDLE,
      S_SCAN,
      S_PRESET,
      S_CONFIRM
   } state_t;

   state_t      state;
   logic [15:0] lfsr;
   logic [63:0] snapshot;
   logic [3:0]  ptr;
   logic [3:0]  scan_cnt;
   logic [3:0]  loc;
   logic [3:0]  val;
   logic [1:0]  pending;
   logic [7:0]  tmo_cnt;

   logic [3:0]  scan_cell;
   logic [3:0]  board_cell;
   logic [3:0]  new_code;

   function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
      lfsr_next = {1'b0, cur[15:1]} ^ (cur[0] ? TAPS : 16'h0000);
   endfunction

   function automatic logic [3:0] cell_at(input logic [63:0] board, input logic [3:0] idx);
      cell_at = board[{idx, 2'b00} +: 4];
   endfunction

   function automatic logic [3:0] tile_code(input logic [3:0] rnd);
      tile_code = ({1'b0, rnd} < THRESH) ? 4'd2 : 4'd1;
   endfunction

   assign scan_cell  = cell_at(snapshot, ptr);
   assign board_cell = cell_at(total_current_state, loc);
   assign new_code   = tile_code(lfsr[11:8]);

   always_ff @(posedge clk) begin
      if (rst) begin
         state             <= S_IDLE;
         lfsr              <= SEED;
         snapshot          <= 64'd0;
         ptr               <= 4'd0;
         scan_cnt          <= 4'd0;
         loc               <= 4'd0;
         val               <= 4'd0;
         pending           <= 2'd0;
         tmo_cnt           <= 8'd0;
         preset_ext        <= 1'b0;
         preset_location   <= 4'd0;
         value_from_preset <= 4'd0;
         busy              <= 1'b0;
         spawn_done        <= 1'b0;
         board_full        <= 1'b0;
         spawn_error       <= 1'b0;
      end else begin
         lfsr              <= lfsr_next(lfsr);
         preset_ext        <= 1'b0;
         preset_location   <= 4'd0;
         value_from_preset <= 4'd0;
         spawn_done        <= 1'b0;
         board_full        <= 1'b0;
         spawn_error       <= 1'b0;

         case (state)
            // busy is still high in the cycle a result pulse is shown, so a request
            // coinciding with the pulse is dropped here and busy clears afterwards.
            S_IDLE: begin
               busy <= 1'b0;
               if (spawn_req && !busy) begin
                  snapshot <= total_current_state;
                  pending  <= spawn_two ? 2'd2 : 2'd1;
                  ptr      <= lfsr[3:0];
                  scan_cnt <= 4'd0;
                  busy     <= 1'b1;
                  state    <= S_SCAN;
               end
            end

            S_SCAN: begin
               if (scan_cell == 4'd0) begin
                  loc               <= ptr;
                  val               <= new_code;
                  preset_ext        <= 1'b1;
                  preset_location   <= ptr;
                  value_from_preset <= new_code;
                  state             <= S_PRESET;
               end else if (scan_cnt != 4'd15) begin
                  ptr      <= ptr + 4'd1;
                  scan_cnt <= scan_cnt + 4'd1;
               end else begin
                  board_full <= 1'b1;
                  pending    <= 2'd0;
                  state      <= S_IDLE;
               end
            end

            // Mark the cell in the snapshot so a second tile skips it.
            S_PRESET: begin
               snapshot[{loc, 2'b00} +: 4] <= val;
               tmo_cnt                     <= 8'd0;
               state                       <= S_CONFIRM;
            end

            S_CONFIRM: begin
               if (board_cell == val) begin
                  if (pending == 2'd1) begin
                     pending    <= 2'd0;
                     spawn_done <= 1'b1;
                     state      <= S_IDLE;
                  end else begin
                     pending  <= pending - 2'd1;
                     ptr      <= lfsr[3:0];
                     scan_cnt <= 4'd0;
                     state    <= S_SCAN;
                  end
               end else if (tmo_cnt == TMO_LAST) begin
                  pending     <= 2'd0;
                  spawn_error <= 1'b1;
                  state       <= S_IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
